// File: rtl/decode_stage.sv
// RISC-V decode/register-read stage: combinational decode of the incoming
// instruction, registered into an output slot backed by a one-entry skid buffer.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [1:0]      pc_sel,
  output logic [1:0]      a_sel,
  output logic            b_sel,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            illegal
);

  localparam logic [1:0]  PC_PLUS_1 = 2'd0, PC_JUMP = 2'd1, PC_BRANCH = 2'd2;
  localparam logic [1:0]  A_REG = 2'd0, A_PC = 2'd1, A_0 = 2'd2;
  localparam logic        B_REG = 1'b0, B_IMM = 1'b1;
  localparam logic [31:0] NOP = 32'h00000013;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_OP = 7'b0110011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011, OP_JALR = 7'b1100111, OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [1:0]      pc_sel;
    logic [1:0]      a_sel;
    logic            b_sel;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            illegal;
  } payload_t;

  payload_t dec, out_q, skid_q;
  logic     out_valid_q, skid_valid_q;

  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = 32'($signed(in_inst[31:20]));
  assign imm_s = 32'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = 32'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = 32'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  always_comb begin
    dec          = '0;
    dec.inst     = in_inst;
    dec.pc       = in_pc;
    dec.rs1      = in_inst[19:15];
    dec.rs2      = in_inst[24:20];
    dec.rd       = in_inst[11:7];
    dec.opcode   = in_inst[6:0];
    dec.funct3   = in_inst[14:12];
    dec.pc_sel   = PC_PLUS_1;
    dec.a_sel    = A_REG;
    dec.b_sel    = B_REG;
    dec.uses_rs1 = 1'b1;
    dec.uses_rs2 = 1'b0;
    dec.illegal  = 1'b0;
    // Every legal opcode ends in 2'b11, so a bad low pair also lands in default.
    case (in_inst[6:0])
      OP_IMM, OP_LOAD: begin dec.imm = XLEN'(imm_i); dec.b_sel = B_IMM; end
      OP_JALR: begin
        dec.imm = XLEN'(imm_i); dec.b_sel = B_IMM; dec.pc_sel = PC_JUMP;
      end
      OP_OP: dec.uses_rs2 = 1'b1;
      OP_LUI: begin
        dec.imm = XLEN'(imm_u); dec.a_sel = A_0; dec.b_sel = B_IMM; dec.uses_rs1 = 1'b0;
      end
      OP_AUIPC: begin
        dec.imm = XLEN'(imm_u); dec.a_sel = A_PC; dec.b_sel = B_IMM; dec.uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        dec.imm = XLEN'(imm_j); dec.a_sel = A_PC; dec.b_sel = B_IMM;
        dec.pc_sel = PC_JUMP; dec.uses_rs1 = 1'b0;
      end
      OP_BRANCH: begin
        dec.imm = XLEN'(imm_b); dec.pc_sel = PC_BRANCH; dec.rd = 5'd0; dec.uses_rs2 = 1'b1;
      end
      OP_STORE: begin
        dec.imm = XLEN'(imm_s); dec.b_sel = B_IMM; dec.rd = 5'd0; dec.uses_rs2 = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1; dec.rd = 5'd0; dec.uses_rs1 = 1'b0;
      end
    endcase
  end

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and payload until then. in_ready is !skid_valid only.
  assign in_ready = !skid_valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      out_q.inst   <= NOP;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q.inst   <= NOP;
    end else if (!out_valid_q || out_ready) begin
      // Output slot frees this edge: the skid entry always goes first.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_valid) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_valid && in_ready) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_q.inst;
  assign out_pc    = out_q.pc;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign imm       = out_q.imm;
  assign opcode    = out_q.opcode;
  assign funct3    = out_q.funct3;
  assign pc_sel    = out_q.pc_sel;
  assign a_sel     = out_q.a_sel;
  assign b_sel     = out_q.b_sel;
  assign uses_rs1  = out_q.uses_rs1;
  assign uses_rs2  = out_q.uses_rs2;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: XLEN=32 and XLEN=64 instances share stimulus and are
// checked every cycle against a queue-based occupancy model and a rule decoder.
module tb_decode_stage;

  localparam logic [1:0]  PC_PLUS_1 = 2'd0, PC_JUMP = 2'd1, PC_BRANCH = 2'd2;
  localparam logic [1:0]  A_REG = 2'd0, A_PC = 2'd1, A_0 = 2'd2;
  localparam logic        B_REG = 1'b0, B_IMM = 1'b1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock, reset_n, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid, b_sel, uses_rs1, uses_rs2, illegal;
  logic [31:0] out_inst, out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  pc_sel, a_sel;

  logic        in_ready_b, out_valid_b, b_sel_b, uses_rs1_b, uses_rs2_b, illegal_b;
  logic [31:0] out_inst_b, out_pc_b;
  logic [63:0] imm_b;
  logic [4:0]  rs1_b, rs2_b, rd_b;
  logic [6:0]  opcode_b;
  logic [2:0]  funct3_b;
  logic [1:0]  pc_sel_b, a_sel_b;

  decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .rs1(rs1), .rs2(rs2),
    .rd(rd), .imm(imm), .opcode(opcode), .funct3(funct3), .pc_sel(pc_sel),
    .a_sel(a_sel), .b_sel(b_sel), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .illegal(illegal)
  );

  decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_inst(out_inst_b), .out_pc(out_pc_b), .rs1(rs1_b),
    .rs2(rs2_b), .rd(rd_b), .imm(imm_b), .opcode(opcode_b), .funct3(funct3_b),
    .pc_sel(pc_sel_b), .a_sel(a_sel_b), .b_sel(b_sel_b), .uses_rs1(uses_rs1_b),
    .uses_rs2(uses_rs2_b), .illegal(illegal_b)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  int          n_dut_out = 0;
  bit          cmp_en = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [1:0]  pc_sel;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic        u1;
    logic        u2;
    logic        ill;
  } dec_t;

  function automatic logic [63:0] sx(input longint v, input int bits);
    longint m;
    m = longint'(1) << (bits - 1);
    v = v & ((m << 1) - 1);
    return 64'((v ^ m) - m);
  endfunction

  // Reference decoder written from the instruction-format rules.
  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d;
    d.rd = i[11:7]; d.imm = '0; d.pc_sel = PC_PLUS_1; d.a_sel = A_REG; d.b_sel = B_REG;
    d.u1 = 1'b1; d.u2 = 1'b0; d.ill = 1'b0;
    case (i[6:0])
      7'b0010011, 7'b0000011: begin d.imm = sx(longint'(i[31:20]), 12); d.b_sel = B_IMM; end
      7'b1100111: begin
        d.imm = sx(longint'(i[31:20]), 12); d.b_sel = B_IMM; d.pc_sel = PC_JUMP;
      end
      7'b0110011: d.u2 = 1'b1;
      7'b0110111: begin
        d.imm = sx(longint'(i[31:12]) * 4096, 32); d.a_sel = A_0; d.b_sel = B_IMM; d.u1 = 1'b0;
      end
      7'b0010111: begin
        d.imm = sx(longint'(i[31:12]) * 4096, 32); d.a_sel = A_PC; d.b_sel = B_IMM; d.u1 = 1'b0;
      end
      7'b1101111: begin
        d.imm = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
                   longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
        d.a_sel = A_PC; d.b_sel = B_IMM; d.pc_sel = PC_JUMP; d.u1 = 1'b0;
      end
      7'b1100011: begin
        d.imm = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                   longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
        d.pc_sel = PC_BRANCH; d.rd = 5'd0; d.u2 = 1'b1;
      end
      7'b0100011: begin
        d.imm = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
        d.b_sel = B_IMM; d.rd = 5'd0; d.u2 = 1'b1;
      end
      default: begin d.ill = 1'b1; d.rd = 5'd0; d.u1 = 1'b0; end
    endcase
    return d;
  endfunction

  // Occupancy model: the stage holds at most two instructions in order.
  always @(negedge reset_n) exp_q.delete();

  always @(posedge clock) begin : model_blk
    int sz;
    if (reset_n) begin
      sz = exp_q.size();
      if (out_valid && out_ready) n_dut_out++;
      if (flush) exp_q.delete();
      else begin
        if (sz > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && sz < 2) exp_q.push_back({in_pc, in_inst});
      end
    end
  end

  always @(negedge clock) begin : compare_blk
    logic [63:0] e;
    dec_t d;
    if (reset_n && cmp_en) begin
      check("out_valid", out_valid, exp_q.size() > 0);
      check("in_ready", in_ready, exp_q.size() < 2);
      check("out_valid64", out_valid_b, exp_q.size() > 0);
      check("in_ready64", in_ready_b, exp_q.size() < 2);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        d = ref_decode(e[31:0]);
        check("out_inst", out_inst, e[31:0]);
        check("out_pc", out_pc, e[63:32]);
        check("rs1", rs1, e[19:15]);
        check("rs2", rs2, e[24:20]);
        check("rd", rd, d.rd);
        check("imm", imm, d.imm[31:0]);
        check("opcode", opcode, e[6:0]);
        check("funct3", funct3, e[14:12]);
        check("pc_sel", pc_sel, d.pc_sel);
        check("a_sel", a_sel, d.a_sel);
        check("b_sel", b_sel, d.b_sel);
        check("uses", {uses_rs1, uses_rs2, illegal}, {d.u1, d.u2, d.ill});
        check("imm64", imm_b, d.imm);
        check("d64_inst", out_inst_b, e[31:0]);
        check("d64_pc", out_pc_b, e[63:32]);
        check("d64_ctl", {rs1_b, rs2_b, rd_b, opcode_b, funct3_b, pc_sel_b, a_sel_b,
                          b_sel_b, uses_rs1_b, uses_rs2_b, illegal_b},
              {e[19:15], e[24:20], d.rd, e[6:0], e[14:12], d.pc_sel, d.a_sel,
               d.b_sel, d.u1, d.u2, d.ill});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    int n;
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) begin
      failures++; checks++;
      $display("FAIL push_timeout act=in_ready_low exp=accept inst=%0h", inst);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops[10];
    logic [31:0] r;
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0110011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100011, 7'b0100011, 7'b0000000};
    r = $urandom();
    if ($urandom_range(0, 9) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  task automatic flush_with(input logic [31:0] inst);
    flush = 1'b1; in_valid = 1'b1; in_inst = inst; in_pc = 32'hDEAD0000;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_out_inst", out_inst, NOP);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int base;
    bit acc;
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (3) @(negedge clock);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_inst", out_inst, NOP);
    check("rst_pc_sel", pc_sel, PC_PLUS_1);
    check("rst_fields", {rd, rs1, rs2, opcode, funct3, out_pc, a_sel, b_sel,
                         uses_rs1, uses_rs2, illegal}, '0);
    check("rst_imm", imm, '0);
    reset_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clock);
    check("post_rst_valid", out_valid, 1'b0);

    // Decode sweep with execute always ready.
    out_ready = 1'b1;
    push(32'hFFF00093, 32'h100);
    check("addi_valid", out_valid, 1'b1);
    check("addi_imm", imm, 32'hFFFFFFFF);
    check("addi_imm64", imm_b, 64'hFFFFFFFFFFFFFFFF);
    check("addi_rd", rd, 5'd1);
    check("addi_b_sel", b_sel, B_IMM);
    push(32'hFE000EE3, 32'h104);
    check("beq_imm", imm, 32'hFFFFFFFC);
    check("beq_rd", rd, 5'd0);
    check("beq_pc_sel", pc_sel, PC_BRANCH);
    check("beq_uses_rs2", uses_rs2, 1'b1);
    push(32'h00112223, 32'h108);
    check("sw_imm", imm, 32'h4);
    check("sw_rd", rd, 5'd0);
    push(32'h123452B7, 32'h10C);
    check("lui_imm", imm, 32'h12345000);
    check("lui_a_sel", a_sel, A_0);
    check("lui_uses_rs1", uses_rs1, 1'b0);
    push(32'h0000007F, 32'h110);
    check("ill_valid", out_valid, 1'b1);
    check("ill_flag", illegal, 1'b1);
    check("ill_rd", rd, 5'd0);
    check("ill_imm", imm, 32'h0);
    check("ill_pc_sel", pc_sel, PC_PLUS_1);
    @(negedge clock);

    // Back-pressure: execute stalls from the second cycle.
    base = n_dut_out;
    fork
      begin
        for (int k = 0; k < 4; k++) push(32'h00100093 + (k << 20), 32'h200 + k * 4);
      end
      begin
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        @(negedge clock);
        check("bp_in_ready_low", in_ready, 1'b0);
        repeat (5) @(negedge clock);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clock);
    check("bp_count", n_dut_out - base, 4);

    // Flush with output and skid both full.
    out_ready = 1'b0;
    push(32'h00A00093, 32'h300);
    push(32'h00B00093, 32'h304);
    flush_with(32'h7FF00093);
    // Flush with only the output full, so the dropped input was acceptable.
    push(32'h00C00093, 32'h308);
    flush_with(32'h7FE00093);
    base = n_dut_out;
    out_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("flush_no_leak", n_dut_out - base, 0);

    // Randomised traffic.
    acc = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || acc || flush) begin
        in_inst = rand_inst();
        in_pc = $urandom();
      end
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 24) == 0;
      acc = in_valid && in_ready && !flush;
      @(negedge clock);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clock);

    // Asynchronous reset mid-stall.
    out_ready = 1'b0;
    push(32'h00D00093, 32'h400);
    push(32'h00E00093, 32'h404);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_valid64", out_valid_b, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_inst", out_inst, NOP);
    #1 reset_n = 1'b1;
    @(negedge clock);
    out_ready = 1'b1;
    push(32'hFFF00093, 32'h500);
    check("post_arst_imm64", imm_b, 64'hFFFFFFFFFFFFFFFF);
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised decode/register-read pipeline stage for the RISC-V core. It sits between fetch and execute. It accepts one instruction and its PC per cycle over a valid/ready handshake. It produces the register indices, the sign-extended immediate, the ALU operand selects, the PC-next select and hazard hints. A one-entry skid buffer absorbs downstream back-pressure, so a stalled execute stage costs no throughput and the stage can be flushed on a redirect.

## Interface
Parameters:
- `XLEN`, 32: datapath width; immediates are sign-extended to `XLEN`. Legal values are 32 and 64.
- `PC_W`, 32: width of the carried PC.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage can accept; registered, equals !skid_valid.
- `in_inst`  in  32  raw instruction.
- `in_pc`  in  PC_W  instruction PC.
- `flush`  in  1  discard all held and incoming instructions.
- `out_valid`  out  1  decoded instruction present.
- `out_ready`  in  1  execute accepts.
- `out_inst`  out  32  instruction passthrough.
- `out_pc`  out  PC_W  PC passthrough.
- `rs1`, `rs2`, `rd`  out  5 each  register indices.
- `imm`  out  XLEN  sign-extended immediate.
- `opcode`  out  7  inst[6:0].
- `funct3`  out  3  inst[14:12].
- `pc_sel`  out  2  `PC_PLUS_1` / `PC_JUMP` / `PC_BRANCH` (codes.v).
- `a_sel`  out  2  `A_REG` / `A_PC` / `A_0`.
- `b_sel`  out  1  `B_REG` / `B_IMM`.
- `uses_rs1`, `uses_rs2`  out  1 each  operand actually read; drives hazard detection.
- `illegal`  out  1  unsupported encoding.

## Operation
- Decode is combinational on the incoming instruction. The result is registered into the output stage or the skid entry.
- Decode per opcode:
  - OP_IMM, LOAD, JALR: I-immediate; `a_sel` = `A_REG`; `b_sel` = `B_IMM`.
  - OP: immediate 0; `A_REG`/`B_REG`.
  - LUI: U-immediate; `A_0`/`B_IMM`.
  - AUIPC: U-immediate; `A_PC`/`B_IMM`.
  - JAL: J-immediate; `A_PC`/`B_IMM`; `pc_sel` = `PC_JUMP`.
  - BRANCH: B-immediate; `A_REG`/`B_REG`; `pc_sel` = `PC_BRANCH`.
  - STORE: S-immediate ({inst[31:25], inst[11:7]}); `A_REG`/`B_IMM`.
  - JALR also drives `pc_sel` = `PC_JUMP`. All other opcodes use `PC_PLUS_1`.
- `rd` is forced to 0 for BRANCH, STORE and illegal instructions, so no spurious writeback occurs.
- `uses_rs1` = 0 for LUI, AUIPC, JAL and illegal; otherwise 1.
- `uses_rs2` = 1 only for OP, BRANCH and STORE.
- `illegal` = 1 when the opcode is outside the nine listed, or when inst[1:0] != 2'b11. In that case: `imm` = 0, `A_REG`/`B_REG`, `PC_PLUS_1`, `rd` = 0. The instruction still flows as a token, so execute can raise the exception.
- Storage: output register (`out_valid` plus payload) and skid entry (`skid_valid` plus payload).
  - Accept occurs when in_valid && in_ready.
  - Output empty, or draining this cycle (out_ready = 1) with the skid empty: the accepted instruction loads the output register.
  - Output holding (out_valid && !out_ready): the accepted instruction loads the skid entry.
  - Output drains while the skid is full: the skid payload moves to the output, and the skid empties. `in_ready` is 0 that cycle, so nothing is accepted.
- Ordering is strictly preserved; no instruction is dropped or duplicated except by `flush`.

## Timing
- Reset (reset_n = 0, asynchronous):
  - `out_valid` = 0, `skid_valid` = 0, `in_ready` = 1.
  - `out_inst` = `NOP` (32'h00000013).
  - `rd`, `rs1`, `rs2`, `opcode`, `funct3`, `imm`, `out_pc` = 0.
  - `pc_sel` = `PC_PLUS_1`, `a_sel` = `A_REG`, `b_sel` = `B_REG`.
  - `uses_rs1` = `uses_rs2` = `illegal` = 0.
- Deassertion is synchronised externally; the first accept can occur on the first edge after release.
- Latency: an instruction accepted at edge N appears with `out_valid` = 1 after edge N when the output is free.
- Throughput: 1 instruction per cycle while `out_ready` = 1.
- `in_ready` falls the cycle after the skid fills. It rises the cycle after the skid drains.
- Payload is stable while out_valid && !out_ready.
- `flush` takes priority over all other events. At the next edge `out_valid` = 0 and `skid_valid` = 0, and any same-cycle input is dropped. Payload registers keep their values, except `out_inst`, which becomes `NOP`.
- Reset asserted mid-stall empties both entries immediately, with no wait for a clock edge.

## Test plan
- Reset: hold reset_n = 0, then release -> out_valid = 0, in_ready = 1, out_inst = 32'h00000013, pc_sel = PC_PLUS_1.
- Decode sweep at out_ready = 1:
  - 32'hFFF00093 (addi x1,x0,-1) -> imm = all ones (XLEN), rd = 1, B_IMM.
  - 32'hFE000EE3 (beq, offset -4) -> imm = -4, rd = 0, PC_BRANCH, uses_rs2 = 1.
  - 32'h00112223 (sw x1,4(x2)) -> imm = 4, rd = 0.
  - 32'h123452B7 (lui x5) -> imm = 32'h12345000, A_0, uses_rs1 = 0.
- Illegal: 32'h0000007F -> illegal = 1, rd = 0, imm = 0, PC_PLUS_1, out_valid = 1.
- Back-pressure: stream 4 instructions while out_ready = 0 from the second cycle -> in_ready = 0 after two accepts. On raising out_ready, outputs appear in order with no loss and no duplicates.
- Flush: output and skid full, assert flush with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, out_inst = NOP, and the flushed-cycle input never appears.
- XLEN = 64 build: I-immediate -1 -> imm = 64'hFFFFFFFFFFFFFFFF. Async reset pulsed mid-cycle -> out_valid drops before the next edge.
